// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_pkg + alu_op_sequencer
//
// Purpose:
//   Multi-cycle issue controller that sits in front of the combinational ALU.
//   It accepts one operation per op_valid/op_ready handshake and registers the
//   operands and control word onto the ALU inputs. Those inputs are held
//   stable for an operation-dependent number of cycles; MULT and DIV are
//   modelled as multi-cycle. It then registers the ALU result and status and
//   offers them on a res_valid/res_ready port. A DIV by zero skips the ALU
//   entirely and returns a canned result together with a one-cycle exception
//   pulse.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-high reset
//   flush      aborts the in-flight op and drops any pending result
//   op_valid   op_a/op_b/op_ctrl carry an operation
//   op_ready   the sequencer can accept an operation this cycle
//   op_a/op_b  16-bit operands
//   op_ctrl    operation select
//   alu_in     registered operands driven to the ALU
//   alu_ctrl   registered operation driven to the ALU
//   alu_out    32-bit ALU result
//   alu_stat   ALU status flags
//   res_valid  res_data/res_stat hold a result
//   res_ready  consumer takes the result
//   res_data   registered 32-bit result
//   res_stat   registered status flags
//   exc_div0   one-cycle pulse after a DIV with op_b == 0 is accepted
//   busy       sequencer is not idle (used by the hazard unit)
// ---------------------------------------------------------------------------

package alu_pkg;

    typedef enum logic [3:0] {
        OR   = 4'd0,
        AND  = 4'd1,
        ROL  = 4'd2,
        ROR  = 4'd3,
        SHL  = 4'd4,
        SHR  = 4'd5,
        ADD  = 4'd6,
        SUB  = 4'd7,
        MULT = 4'd8,
        DIV  = 4'd9
    } control_e;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } in_t;

    typedef struct packed {
        logic zero;
        logic div0;
        logic overflow;
        logic sign;
    } status_t;

endpackage

module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int BASE_CYCLES = 1,
    parameter int MULT_CYCLES = 3,
    parameter int DIV_CYCLES  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  control_e    op_ctrl,
    output in_t         alu_in,
    output control_e    alu_ctrl,
    input  logic [31:0] alu_out,
    input  status_t     alu_stat,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output status_t     res_stat,
    output logic        exc_div0,
    output logic        busy
);

    localparam int MAX_BM     = (BASE_CYCLES > MULT_CYCLES) ? BASE_CYCLES : MULT_CYCLES;
    localparam int MAX_CYCLES = (MAX_BM > DIV_CYCLES) ? MAX_BM : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    // The counter is loaded with LAT-1 so that the cycle in which it reads
    // zero is the last EXEC cycle and the capture edge lands at accept+LAT.
    localparam logic [CNT_W-1:0] BASE_LAT = CNT_W'(BASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    in_t                alu_in_q,   alu_in_d;
    control_e           alu_ctrl_q, alu_ctrl_d;
    logic [31:0]        res_data_q, res_data_d;
    status_t            res_stat_q, res_stat_d;
    logic               exc_div0_q, exc_div0_d;

    logic               accept;
    logic               div_by_zero;
    logic [CNT_W-1:0]   op_lat;

    // A new op may enter when idle, or in DONE when the current result is
    // being taken in the same cycle; that gives back-to-back issue with no
    // idle bubble. Flush blocks any accept.
    assign op_ready    = !flush && ((state_q == IDLE) || ((state_q == DONE) && res_ready));
    assign accept      = op_valid && op_ready;
    assign div_by_zero = (op_ctrl == DIV) && (op_b == 16'd0);

    assign alu_in    = alu_in_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign res_valid = (state_q == DONE);
    assign res_data  = res_data_q;
    assign res_stat  = res_stat_q;
    assign exc_div0  = exc_div0_q;
    assign busy      = (state_q != IDLE);

    // Pick the EXEC latency for the incoming op; unknown encodings are
    // treated like the single-cycle base ops.
    always_comb begin
        op_lat = BASE_LAT;
        case (op_ctrl)
            MULT:    op_lat = MULT_LAT;
            DIV:     op_lat = DIV_LAT;
            default: op_lat = BASE_LAT;
        endcase
    end

    // Next-state logic. Flush overrides everything: it returns to IDLE,
    // clears the counter and suppresses the accept through op_ready.
    // Operand and result registers simply hold unless explicitly loaded.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alu_in_d   = alu_in_q;
        alu_ctrl_d = alu_ctrl_q;
        res_data_d = res_data_q;
        res_stat_d = res_stat_q;
        exc_div0_d = 1'b0;

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        res_data_d = alu_out;
                        res_stat_d = alu_stat;
                        state_d    = DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // An accept in DONE overrides the IDLE transition chosen above.
            if (accept) begin
                alu_in_d.a = op_a;
                alu_in_d.b = op_b;
                alu_ctrl_d = op_ctrl;
                if (div_by_zero) begin
                    // Divide by zero never reaches the ALU; the canned
                    // result is presented in DONE on the very next cycle.
                    cnt_d               = '0;
                    res_data_d          = 32'd0;
                    res_stat_d.zero     = 1'b1;
                    res_stat_d.div0     = 1'b1;
                    res_stat_d.overflow = 1'b0;
                    res_stat_d.sign     = 1'b0;
                    exc_div0_d          = 1'b1;
                    state_d             = DONE;
                end else begin
                    cnt_d   = op_lat;
                    state_d = EXEC;
                end
            end
        end
    end

    // State register. Reset drops any in-flight op and returns the ALU
    // drive to a neutral ADD of zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            alu_in_q   <= '0;
            alu_ctrl_q <= ADD;
            res_data_q <= '0;
            res_stat_q <= '0;
            exc_div0_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_in_q   <= alu_in_d;
            alu_ctrl_q <= alu_ctrl_d;
            res_data_q <= res_data_d;
            res_stat_q <= res_stat_d;
            exc_div0_q <= exc_div0_d;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Directed bench for alu_op_sequencer. A small behavioural ALU drives
// alu_out/alu_stat from the sequencer's registered operands. Each issued op
// pushes its hand-computed result onto a queue, and a monitor pops and
// compares on every result handshake. Latency, stall, flush and reset
// behaviour are checked inline by the stimulus process.
// ---------------------------------------------------------------------------

module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    control_e    op_ctrl;
    in_t         alu_in;
    control_e    alu_ctrl;
    logic [31:0] alu_out;
    status_t     alu_stat;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    status_t     res_stat;
    logic        exc_div0;
    logic        busy;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  stat;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   failCount  = 0;
    int   cycle      = 0;

    alu_op_sequencer #(
        .BASE_CYCLES(1),
        .MULT_CYCLES(3),
        .DIV_CYCLES (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_ctrl  (op_ctrl),
        .alu_in   (alu_in),
        .alu_ctrl (alu_ctrl),
        .alu_out  (alu_out),
        .alu_stat (alu_stat),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_stat (res_stat),
        .exc_div0 (exc_div0),
        .busy     (busy)
    );

    // Free-running clock with a cycle counter used for latency measurement.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural ALU: 16-bit ops zero-extended, MULT gives the full 32-bit
    // product, DIV packs remainder in [31:16] and quotient in [15:0].
    always_comb begin
        logic [15:0] r16;
        r16      = '0;
        alu_out  = '0;
        alu_stat = '0;
        case (alu_ctrl)
            OR:   begin r16 = alu_in.a | alu_in.b; alu_out = {16'd0, r16}; alu_stat.sign = r16[15]; end
            AND:  begin r16 = alu_in.a & alu_in.b; alu_out = {16'd0, r16}; alu_stat.sign = r16[15]; end
            ROL:  begin r16 = {alu_in.a[14:0], alu_in.a[15]}; alu_out = {16'd0, r16}; alu_stat.sign = r16[15]; end
            ROR:  begin r16 = {alu_in.a[0], alu_in.a[15:1]}; alu_out = {16'd0, r16}; alu_stat.sign = r16[15]; end
            SHL:  begin r16 = {alu_in.a[14:0], 1'b0}; alu_out = {16'd0, r16}; alu_stat.sign = r16[15]; end
            SHR:  begin r16 = {1'b0, alu_in.a[15:1]}; alu_out = {16'd0, r16}; alu_stat.sign = r16[15]; end
            ADD: begin
                r16 = alu_in.a + alu_in.b;
                alu_out = {16'd0, r16};
                alu_stat.sign = r16[15];
                alu_stat.overflow = (alu_in.a[15] == alu_in.b[15]) && (r16[15] != alu_in.a[15]);
            end
            SUB: begin
                r16 = alu_in.a - alu_in.b;
                alu_out = {16'd0, r16};
                alu_stat.sign = r16[15];
                alu_stat.overflow = (alu_in.a[15] != alu_in.b[15]) && (r16[15] != alu_in.a[15]);
            end
            MULT: begin
                alu_out = 32'(alu_in.a) * 32'(alu_in.b);
                alu_stat.sign = alu_out[31];
            end
            DIV: begin
                if (alu_in.b == 16'd0) begin
                    alu_stat.div0 = 1'b1;
                end else begin
                    alu_out = {alu_in.a % alu_in.b, alu_in.a / alu_in.b};
                end
            end
            default: alu_out = '0;
        endcase
        alu_stat.zero = (alu_out == 32'd0);
    end

    // Single comparison point: every check goes through here so the
    // counters always match what was printed.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Present an op, wait (bounded) for op_ready, and return the cycle of
    // the accepting edge. Optionally queue the expected result, and
    // optionally leave op_valid high for back-to-back issue.
    task automatic applyStimulus(input control_e ctrl, input logic [15:0] a, input logic [15:0] b,
                                 input logic doPush, input logic [31:0] expData, input logic [3:0] expStat,
                                 input logic holdValid, output int acceptCycle);
        bit accepted;
        exp_t e;
        accepted = 1'b0;
        op_ctrl  = ctrl;
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (op_ready) begin
                @(posedge clk);
                #1;
                accepted = 1'b1;
            end
        end
        acceptCycle = cycle;
        if (!accepted) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL accept timeout: op_ready never rose for op %0d", ctrl);
        end else if (doPush) begin
            e.data = expData;
            e.stat = expStat;
            expQ.push_back(e);
        end
        if (!holdValid) op_valid = 1'b0;
    endtask

    // Count edges from accept until res_valid rises, checking that the ALU
    // operands stay put for the whole EXEC window.
    task automatic waitResult(input logic [15:0] a, input logic [15:0] b, output int lat);
        lat = 0;
        while (!res_valid && lat < 100) begin
            checkOutput("alu_in held", alu_in, {a, b});
            @(posedge clk);
            #1;
            lat++;
        end
        if (!res_valid) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL result timeout: res_valid got 0 expected 1");
        end
    endtask

    // Scoreboard monitor: compare on every result handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && res_valid && res_ready) begin
            if (expQ.size() == 0) begin
                checkCount++;
                failCount++;
                $display("[TB] FAIL unexpected result: got data %h stat %b expected none", res_data, res_stat);
            end else begin
                e = expQ.pop_front();
                checkOutput("res_data", res_data, e.data);
                checkOutput("res_stat", {28'd0, res_stat}, {28'd0, e.stat});
            end
        end
    end

    // Watchdog so the bench always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed stimulus.
    initial begin
        int acc;
        int acc2;
        int lat;

        rst       = 1'b1;
        flush     = 1'b0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_ctrl   = ADD;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset op_ready", {31'd0, op_ready}, 32'd1);
        checkOutput("reset res_data", res_data, 32'd0);
        checkOutput("reset res_stat", {28'd0, res_stat}, 32'd0);
        checkOutput("reset exc_div0", {31'd0, exc_div0}, 32'd0);
        checkOutput("reset alu_in", alu_in, 32'd0);
        checkOutput("reset alu_ctrl", 32'(alu_ctrl), 32'd6);

        res_ready = 1'b1;

        $display("[TB] ADD overflow");
        applyStimulus(ADD, 16'h7FFF, 16'h0001, 1'b1, 32'h0000_8000, 4'b0011, 1'b0, acc);
        waitResult(16'h7FFF, 16'h0001, lat);
        checkOutput("ADD latency", 32'(lat), 32'd1);

        $display("[TB] MULT");
        applyStimulus(MULT, 16'd300, 16'd300, 1'b1, 32'd90000, 4'b0000, 1'b0, acc);
        checkOutput("MULT alu_ctrl", 32'(alu_ctrl), 32'd8);
        waitResult(16'd300, 16'd300, lat);
        checkOutput("MULT latency", 32'(lat), 32'd3);

        $display("[TB] DIV");
        applyStimulus(DIV, 16'd17, 16'd5, 1'b1, 32'h0002_0003, 4'b0000, 1'b0, acc);
        waitResult(16'd17, 16'd5, lat);
        checkOutput("DIV latency", 32'(lat), 32'd8);

        $display("[TB] DIV by zero");
        applyStimulus(DIV, 16'd9, 16'd0, 1'b1, 32'd0, 4'b1100, 1'b0, acc);
        checkOutput("DIV0 res_valid next cycle", {31'd0, res_valid}, 32'd1);
        checkOutput("DIV0 exc_div0 pulse", {31'd0, exc_div0}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("DIV0 exc_div0 cleared", {31'd0, exc_div0}, 32'd0);

        $display("[TB] back-to-back");
        applyStimulus(SUB, 16'd5, 16'd3, 1'b1, 32'd2, 4'b0000, 1'b1, acc);
        applyStimulus(OR, 16'h00F0, 16'h000F, 1'b1, 32'h0000_00FF, 4'b0000, 1'b0, acc2);
        checkOutput("b2b accept spacing", 32'(acc2 - acc), 32'd2);
        waitResult(16'h00F0, 16'h000F, lat);
        checkOutput("b2b OR latency", 32'(lat), 32'd1);

        $display("[TB] backpressure");
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        applyStimulus(ADD, 16'd1, 16'd2, 1'b1, 32'd3, 4'b0000, 1'b0, acc);
        waitResult(16'd1, 16'd2, lat);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall res_data", res_data, 32'd3);
            checkOutput("stall op_ready", {31'd0, op_ready}, 32'd0);
            checkOutput("stall busy", {31'd0, busy}, 32'd1);
            checkOutput("stall res_valid", {31'd0, res_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release busy", {31'd0, busy}, 32'd0);
        checkOutput("release res_valid", {31'd0, res_valid}, 32'd0);

        $display("[TB] flush during DIV");
        applyStimulus(DIV, 16'd100, 16'd7, 1'b0, 32'd0, 4'b0000, 1'b0, acc);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pre-flush busy", {31'd0, busy}, 32'd1);
        flush    = 1'b1;
        op_valid = 1'b1;
        op_ctrl  = ADD;
        op_a     = 16'd1;
        op_b     = 16'd1;
        checkOutput("flush op_ready", {31'd0, op_ready}, 32'd0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        op_valid = 1'b0;
        checkOutput("post-flush busy", {31'd0, busy}, 32'd0);
        checkOutput("post-flush res_valid", {31'd0, res_valid}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("flushed DIV no result", {31'd0, res_valid}, 32'd0);
        applyStimulus(ADD, 16'd4, 16'd4, 1'b1, 32'd8, 4'b0000, 1'b0, acc);
        waitResult(16'd4, 16'd4, lat);
        checkOutput("post-flush ADD latency", 32'(lat), 32'd1);

        $display("[TB] reset during MULT");
        @(posedge clk);
        #1;
        applyStimulus(MULT, 16'd7, 16'd6, 1'b0, 32'd0, 4'b0000, 1'b0, acc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mid-rst busy", {31'd0, busy}, 32'd0);
        checkOutput("mid-rst res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("mid-rst alu_in", alu_in, 32'd0);
        checkOutput("mid-rst alu_ctrl", 32'(alu_ctrl), 32'd6);
        checkOutput("mid-rst op_ready", {31'd0, op_ready}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("reset MULT no result", {31'd0, res_valid}, 32'd0);
        applyStimulus(SUB, 16'd10, 16'd4, 1'b1, 32'd6, 4'b0000, 1'b0, acc);
        waitResult(16'd10, 16'd4, lat);
        checkOutput("post-rst SUB latency", 32'(lat), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
